// File: rtl/uart_pulse_cmd.sv
// UART command parser for the pulse generator: validates framed width/gap
// settings, acks each frame on the uart_tx path and fires the trigger strobe.
module uart_pulse_cmd #(
  parameter int NCH         = 2,
  parameter int WW          = 16,
  parameter int MIN_VAL     = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              key_trig,
  output logic [NCH-1:0]    ch_enable,
  output logic [NCH*WW-1:0] ch_width,
  output logic [WW-1:0]     pulse_gap,
  output logic              trig_out,
  output logic [7:0]        ack_data,
  output logic              ack_valid,
  output logic [7:0]        err_cnt
);

  localparam int L  = 5 + 2*NCH;
  localparam int SB = WW*(NCH+1);
  localparam int CW = $clog2(L+1);
  localparam int TW = $clog2(TIMEOUT_CYC+1);

  localparam logic [7:0]    HDR    = 8'h07;
  localparam logic [7:0]    ACK_OK = 8'hA5;
  localparam logic [7:0]    ACK_CS = 8'hE1;
  localparam logic [7:0]    ACK_TO = 8'hE3;
  localparam logic [WW-1:0] MINV   = WW'(MIN_VAL);
  localparam logic [WW-1:0] RSTV   = WW'(5);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CHECK
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [TW-1:0]     r_tmr;
  logic [7:0]        r_xor;
  logic [NCH-1:0]    r_mask;
  logic [SB-1:0]     r_sh;
  logic              r_ok;
  logic [NCH-1:0]    r_en;
  logic [NCH*WW-1:0] r_width;
  logic [WW-1:0]     r_gap;
  logic              r_trig;
  logic [7:0]        r_ack;
  logic              r_ack_vld;
  logic [7:0]        r_err;

  logic w_last;
  logic w_match;
  logic w_tmo;

  assign w_last  = (r_cnt == CW'(L-1));
  assign w_match = (r_xor == rx_data);
  assign w_tmo   = (r_tmr == TW'(TIMEOUT_CYC-1));

  function automatic logic [WW-1:0] f_clamp(input logic [WW-1:0] v);
    return (v < MINV) ? MINV : v;
  endfunction

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tmr     <= '0;
      r_xor     <= '0;
      r_mask    <= '0;
      r_sh      <= '0;
      r_ok      <= 1'b0;
      r_en      <= '0;
      r_width   <= {NCH{RSTV}};
      r_gap     <= RSTV;
      r_trig    <= 1'b0;
      r_ack     <= '0;
      r_ack_vld <= 1'b0;
      r_err     <= '0;
    end else begin
      r_ack_vld <= 1'b0;
      r_trig    <= key_trig;
      unique case (r_state)
        S_IDLE: begin
          if (rx_valid && rx_data == HDR) begin
            r_state <= S_PAYLOAD;
            r_cnt   <= CW'(1);
            r_xor   <= HDR;
            r_tmr   <= '0;
          end
        end
        S_PAYLOAD: begin
          if (rx_valid) begin
            r_tmr <= '0;
            r_cnt <= r_cnt + CW'(1);
            r_xor <= r_xor ^ rx_data;
            if (r_cnt == CW'(1))
              r_mask <= rx_data[NCH-1:0];
            else if (!w_last)
              r_sh <= {r_sh[SB-9:0], rx_data};
            if (w_last) begin
              r_state   <= S_CHECK;
              r_ok      <= w_match;
              r_ack_vld <= 1'b1;
              if (w_match) begin
                r_ack <= ACK_OK;
                r_en  <= r_mask;
                for (int k = 0; k < NCH; k++)
                  r_width[WW*k +: WW] <= f_clamp(r_sh[SB-1-WW*k -: WW]);
                r_gap <= f_clamp(r_sh[WW-1:0]);
              end else begin
                r_ack <= ACK_CS;
                if (r_err != 8'hFF) r_err <= r_err + 8'd1;
              end
            end
          end else if (w_tmo) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tmr     <= '0;
            r_ack     <= ACK_TO;
            r_ack_vld <= 1'b1;
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_CHECK: begin
          // key and frame triggers landing together merge into one strobe
          r_trig  <= key_trig | r_ok;
          r_ok    <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch_enable = r_en;
  assign ch_width  = r_width;
  assign pulse_gap = r_gap;
  assign trig_out  = r_trig;
  assign ack_data  = r_ack;
  assign ack_valid = r_ack_vld;
  assign err_cnt   = r_err;

endmodule

// File: tb/tb_uart_pulse_cmd.sv
// Directed bench for uart_pulse_cmd (NCH=2): frames, checksum errors,
// timeout, key/frame trigger merge, reset mid-frame, err_cnt saturation.
module tb_uart_pulse_cmd;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        key_trig;
  logic [1:0]  ch_enable;
  logic [31:0] ch_width;
  logic [15:0] pulse_gap;
  logic        trig_out;
  logic [7:0]  ack_data;
  logic        ack_valid;
  logic [7:0]  err_cnt;

  int n_chk = 0;
  int n_err = 0;

  uart_pulse_cmd #(
    .NCH(2),
    .WW(16),
    .MIN_VAL(4),
    .TIMEOUT_CYC(50000)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .key_trig(key_trig),
    .ch_enable(ch_enable),
    .ch_width(ch_width),
    .pulse_gap(pulse_gap),
    .trig_out(trig_out),
    .ack_data(ack_data),
    .ack_valid(ack_valid),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic send_frame(input logic [71:0] f, input logic ok,
                            input logic key);
    for (int i = 8; i >= 1; i--) send_byte(f[8*i +: 8]);
    rx_data  = f[7:0];
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    key_trig = key;
    chk("ack_v", {31'd0, ack_valid}, 32'd1);
    chk("ack_d", {24'd0, ack_data}, ok ? 32'hA5 : 32'hE1);
    chk("trig_n1", {31'd0, trig_out}, 32'd0);
    tick();
    key_trig = 1'b0;
    chk("trig_n2", {31'd0, trig_out}, {31'd0, ok | key});
    chk("ack_v_n2", {31'd0, ack_valid}, 32'd0);
    tick();
    chk("trig_n3", {31'd0, trig_out}, 32'd0);
  endtask

  task automatic chk_out(input string tag, input logic [1:0] en,
                         input logic [31:0] w, input logic [15:0] g);
    chk({tag, "_en"}, {30'd0, ch_enable}, {30'd0, en});
    chk({tag, "_w"}, ch_width, w);
    chk({tag, "_gap"}, {16'd0, pulse_gap}, {16'd0, g});
  endtask

  localparam logic [71:0] F1  = 72'h07_03_000A_0014_0008_12;
  localparam logic [71:0] F2  = 72'h07_01_0002_0000_0001_05;
  localparam logic [71:0] F3  = 72'h07_03_000A_0014_0008_13;
  localparam logic [71:0] F07 = 72'h07_07_0007_0007_0007_07;
  localparam logic [71:0] FCL = 72'h07_02_0004_0003_0005_07;

  initial begin
    int w;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    key_trig = 1'b0;
    repeat (3) tick();
    chk_out("rst", 2'b00, 32'h0005_0005, 16'd5);
    chk("rst_trig", {31'd0, trig_out}, 32'd0);
    chk("rst_ackd", {24'd0, ack_data}, 32'd0);
    chk("rst_ackv", {31'd0, ack_valid}, 32'd0);
    chk("rst_err", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    send_frame(F1, 1'b1, 1'b0);
    chk_out("f1", 2'b11, 32'h0014_000A, 16'd8);

    send_frame(F2, 1'b1, 1'b0);
    chk_out("f2", 2'b01, 32'h0004_0004, 16'd4);

    send_frame(F3, 1'b0, 1'b0);
    chk_out("f3", 2'b01, 32'h0004_0004, 16'd4);
    chk("f3_err", {24'd0, err_cnt}, 32'd1);

    send_byte(8'h07);
    send_byte(8'h03);
    send_byte(8'h00);
    w = 0;
    while (!ack_valid && w < 60000) begin
      tick();
      w++;
    end
    chk("to_cyc", w, 32'd49999);
    chk("to_ack", {24'd0, ack_data}, 32'hE3);
    chk("to_err", {24'd0, err_cnt}, 32'd2);
    tick();
    chk("to_ackv", {31'd0, ack_valid}, 32'd0);
    chk_out("to", 2'b01, 32'h0004_0004, 16'd4);

    send_byte(8'h55);
    send_byte(8'hAA);
    send_frame(F1, 1'b1, 1'b1);
    chk_out("jk", 2'b11, 32'h0014_000A, 16'd8);
    chk("jk_err", {24'd0, err_cnt}, 32'd2);

    key_trig = 1'b1;
    tick();
    key_trig = 1'b0;
    chk("key_m1", {31'd0, trig_out}, 32'd1);
    tick();
    chk("key_m2", {31'd0, trig_out}, 32'd0);

    send_frame(F07, 1'b1, 1'b0);
    chk_out("f07", 2'b11, 32'h0007_0007, 16'd7);

    send_frame(FCL, 1'b1, 1'b0);
    chk_out("fcl", 2'b10, 32'h0004_0004, 16'd5);

    send_byte(8'h07);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h0A);
    rst_n = 1'b0;
    tick();
    chk_out("mrst", 2'b00, 32'h0005_0005, 16'd5);
    chk("mrst_err", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();
    send_frame(F1, 1'b1, 1'b0);
    chk_out("mrst_f1", 2'b11, 32'h0014_000A, 16'd8);

    for (int i = 0; i < 256; i++) begin
      send_frame(F3, 1'b0, 1'b0);
      tick();
    end
    chk("sat_err", {24'd0, err_cnt}, 32'd255);
    chk_out("sat", 2'b11, 32'h0014_000A, 16'd8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_pulse_cmd.md
UART_PULSE_CMD -- requirements
Module: uart_pulse_cmd

Interface
REQ-001 Parameter NCH, default 2, meaning number of pulse channels; legal range 1..8.
REQ-002 Parameter WW, default 16, meaning width of each pulse-width/gap field; fixed at 16, sent as 2 bytes, MSB first.
REQ-003 Parameter MIN_VAL, default 4, meaning minimum legal width/gap in sys_clk cycles.
REQ-004 Parameter TIMEOUT_CYC, default 50000, meaning inter-byte timeout in cycles (1 ms at 50 MHz).
REQ-005 sys_clk  input  1  system clock, 50 MHz; the only clock.
REQ-006 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-007 rx_data  input  8  received UART byte; valid only while rx_valid=1.
REQ-008 rx_valid  input  1  one-cycle strobe per received byte, synchronous to sys_clk.
REQ-009 key_trig  input  1  one-cycle debounced key strobe.
REQ-010 ch_enable  output  NCH  per-channel enable.
REQ-011 ch_width  output  NCH*16  per-channel pulse width, channel k at bits [16k+15:16k].
REQ-012 pulse_gap  output  16  inter-pulse gap.
REQ-013 trig_out  output  1  one-cycle strobe to the pulse generator.
REQ-014 ack_data  output  8  status byte for uart_tx pi_data.
REQ-015 ack_valid  output  1  one-cycle strobe for uart_tx pi_flag.
REQ-016 err_cnt  output  8  saturating count of rejected frames.

Function
REQ-017 All logic SHALL be clocked by sys_clk only; rx_valid SHALL be sampled as a data strobe, never used as a clock.
REQ-018 Frame length L = 5 + 2*NCH bytes: header 0x07, enable mask, NCH width pairs (channel 0 first), gap pair, checksum.
REQ-019 Checksum byte SHALL equal the XOR of all preceding L-1 frame bytes.
REQ-020 States: IDLE, PAYLOAD, CHECK; reset state IDLE.
REQ-021 IDLE: rx_valid with rx_data=0x07 -> PAYLOAD, byte counter=1, running XOR=0x07; any other byte discarded silently, no ack, no err_cnt change.
REQ-022 PAYLOAD: each rx_valid stores the byte into a shadow register, XORs it, increments counter; the byte received at counter=L-1 is the checksum -> CHECK.
REQ-023 0x07 bytes received in PAYLOAD SHALL be treated as data.
REQ-024 CHECK (one cycle, cycle N+1 after checksum strobe at N): on match, copy shadow to outputs, ack_data=0xA5, ack_valid=1; on mismatch, outputs unchanged, ack_data=0xE1, ack_valid=1, err_cnt+1; then -> IDLE.
REQ-025 On match, trig_out SHALL pulse at cycle N+2, so the generator samples updated width/gap/enable.
REQ-026 Width/gap values < MIN_VAL SHALL be clamped to MIN_VAL when copied; values >= MIN_VAL pass unchanged.
REQ-027 Mask bits [7:NCH] SHALL be ignored; ch_enable[k] = mask bit k.
REQ-028 PAYLOAD with no rx_valid for TIMEOUT_CYC consecutive cycles -> IDLE, ack_data=0xE3, ack_valid=1, err_cnt+1, shadow discarded; timer resets on every rx_valid.
REQ-029 key_trig=1 at cycle M -> trig_out=1 at M+1 using current outputs, in any state.
REQ-030 key trigger and frame trigger due in the same cycle SHALL produce one single-cycle trig_out pulse.
REQ-031 err_cnt SHALL saturate at 255.
REQ-032 ack_valid and trig_out SHALL never be high for two consecutive cycles from one event.

Reset
REQ-033 Reset values: ch_enable=0, every ch_width=5, pulse_gap=5, trig_out=0, ack_data=0x00, ack_valid=0, err_cnt=0, state IDLE, counter 0, timer 0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; the first byte after release is parsed from IDLE.

Verification (NCH=2)
REQ-035 Bytes 07 03 00 0A 00 14 00 08 12 -> ch_enable=11, ch_width0=10, ch_width1=20, gap=8, ack 0xA5 at N+1, trig_out at N+2.
REQ-036 Bytes 07 01 00 02 00 00 00 01 05 -> widths 4/4, gap 4, ch_enable=01, ack 0xA5.
REQ-037 Same as REQ-035 with checksum 13 -> outputs keep prior values, ack 0xE1, err_cnt=1, no trig_out.
REQ-038 Bytes 07 03 00 then silence 50000 cycles -> ack 0xE3, err_cnt+1; next valid frame accepted normally.
REQ-039 Junk 55 AA then valid frame; key_trig in same cycle as frame trig -> junk ignored, exactly one trig_out pulse.
REQ-040 Reset after 4 frame bytes, then full valid frame -> reset values, then frame applied, ack 0xA5.
